seg7_reader: RTL
================

Name: seg7_reader

Overview:
- Inverse of the board's seven-segment hex decoder. Samples a 7-bit active-low segment bus in the DE10 Lite HEX format and recovers the 4-bit hex value it shows.
- Filters glitches by requiring the pattern to hold for a set number of cycles before it is accepted.
- Flags and counts illegal patterns.
- Used as a loop-back checker for the display path (decoder output → seg7_reader → compare against SW) and as a monitor in board-level benches.

Parameters:
- STABLE_CYCLES, 4, consecutive equal samples needed to commit a pattern; legal range ≥2.
- ERR_CNT_W, 8, width of the saturating illegal-pattern counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- seg  input  7  segment bus, active-low; bit0=a … bit6=g
- value  output  4  last committed hex digit
- valid  output  1  high while the committed pattern is a legal glyph
- blank  output  1  high while the committed pattern is all-off (7'h7F)
- err  output  1  high while the committed pattern is illegal
- changed  output  1  one-cycle pulse when a legal glyph is committed whose digit differs from the previous `value`, or when `valid` was low before the commit
- err_count  output  ERR_CNT_W  number of illegal commits, saturating

Behaviour:
- Reset (synchronous):
  - seg_q=7'h7F, cand=7'h7F, cnt=0, state=SETTLE.
  - value=0, valid=0, blank=0, err=0, changed=0, err_count=0.
- Input sampling: seg_q<=seg every cycle (single sampling register; no synchroniser implied).
- Glyph table, active-low (glyph→digit):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - 7F = blank. Every other code is illegal.
- FSM states SETTLE / STABLE:
  - Any state, seg_q != cand: cand<=seg_q, cnt<=1, state<=SETTLE. Outputs hold their last committed values.
  - SETTLE, seg_q == cand, cnt < STABLE_CYCLES-1: cnt<=cnt+1.
  - SETTLE, seg_q == cand, cnt == STABLE_CYCLES-1: commit, cnt<=STABLE_CYCLES, state<=STABLE.
  - STABLE, seg_q == cand: hold. No re-commit, so no repeated `changed` and no double error count.
- Commit of a legal glyph:
  - value<=digit, valid<=1, blank<=0, err<=0.
  - changed<=1 if (!valid || digit != value).
- Commit of blank: valid<=0, blank<=1, err<=0, value holds, changed<=0. Not counted as an error.
- Commit of an illegal code:
  - valid<=0, blank<=0, err<=1, value holds, changed<=0.
  - err_count<=err_count+1, saturating at all-ones.
- `changed` is high for exactly one cycle per qualifying commit; it is 0 in every other cycle.
- Latency: seg driven to P before edge k (P != cand) → seg_q=P after edge k → commit at edge k+STABLE_CYCLES.
  - Default STABLE_CYCLES=4: outputs show P after edge k+4.
- Glitch rule: any sample that differs restarts the count. A pattern that holds for fewer than STABLE_CYCLES samples is never committed.
- Reset after reset: seg held at 7F commits blank at edge STABLE_CYCLES-1+1 counting from cnt=0.
  - cand already equals 7F, so cnt counts 0→STABLE_CYCLES-1 and then commits.
- Reset mid-settle: all state is discarded and the outputs return to their reset values on the next edge.
- Reset has priority over every other event in the same cycle.

Optional Feature:
- Macro SEG_ALT_GLYPHS_EN.
- Defined: the alternate glyphs are also legal.
  - 58→7 (seven with segment f lit).
  - 18→9 (nine without segment d).
  - They commit exactly like the primary glyphs: `changed` compares digits only, so 78→58 gives no pulse.
- Undefined: 58 and 18 are illegal codes; they set `err` and increment `err_count`.

Test Plan:
- Reset then hold seg=7F → after STABLE_CYCLES edges blank=1, valid=0, err=0, err_count=0, changed never high.
- Sweep all 16 primary glyphs, each held for 8 cycles → value=0..F in order, valid=1, exactly 16 `changed` pulses, each one cycle wide, each 4 edges after seg_q updates.
- seg=30 (3), then a 3-cycle blip to 24, back to 30 → value stays 3, no `changed`, no err. Then hold 24 → value=2 with one `changed` pulse.
- Hold illegal 7E for 10 cycles, then 7C for 10 cycles → err=1, valid=0, err_count=2, value retains its prior digit. With ERR_CNT_W=2, six illegal commits → err_count saturates at 3.
- seg=12 (5), then 12 again after a blank commit → `changed` pulses both times because `valid` was low. 5→5 with no blank in between → no pulse.
- Assert reset 2 cycles into settling on 0E → all outputs are at reset values on the next edge, and F is not committed until STABLE_CYCLES edges after reset is released.
- SEG_ALT_GLYPHS_EN defined/undefined: hold 58 → value=7, valid=1 / err=1, err_count=1.

Source files
------------

// File: rtl/seg7_reader.sv
// Recovers the hex digit shown on an active-low DE10 Lite seven-segment bus, with glitch filtering
// and a saturating illegal-pattern counter. Define SEG_ALT_GLYPHS_EN to accept the alternate 7 and 9 glyphs.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           seg,
    output logic [3:0]           value,
    output logic                 valid,
    output logic                 blank,
    output logic                 err,
    output logic                 changed,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {
        SETTLE,
        STABLE
    } state_t;

    state_t               state, state_n;
    logic [6:0]           seg_q;
    logic [6:0]           cand, cand_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [3:0]           value_n;
    logic                 valid_n, blank_n, err_n, changed_n;
    logic [ERR_CNT_W-1:0] err_count_n;

    logic                 code_legal;
    logic                 code_blank;
    logic [3:0]           code_digit;

    // Classify the candidate pattern; it equals seg_q whenever a commit can happen.
    always_comb begin
        code_legal = 1'b1;
        code_blank = 1'b0;
        code_digit = 4'h0;
        case (cand)
            7'h40: code_digit = 4'h0;
            7'h79: code_digit = 4'h1;
            7'h24: code_digit = 4'h2;
            7'h30: code_digit = 4'h3;
            7'h19: code_digit = 4'h4;
            7'h12: code_digit = 4'h5;
            7'h02: code_digit = 4'h6;
            7'h78: code_digit = 4'h7;
            7'h00: code_digit = 4'h8;
            7'h10: code_digit = 4'h9;
            7'h08: code_digit = 4'hA;
            7'h03: code_digit = 4'hB;
            7'h46: code_digit = 4'hC;
            7'h21: code_digit = 4'hD;
            7'h06: code_digit = 4'hE;
            7'h0E: code_digit = 4'hF;
`ifdef SEG_ALT_GLYPHS_EN
            7'h58: code_digit = 4'h7;
            7'h18: code_digit = 4'h9;
`endif
            7'h7F: begin
                code_legal = 1'b0;
                code_blank = 1'b1;
            end
            default: code_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n     = state;
        cand_n      = cand;
        cnt_n       = cnt;
        value_n     = value;
        valid_n     = valid;
        blank_n     = blank;
        err_n       = err;
        changed_n   = 1'b0;
        err_count_n = err_count;

        if (seg_q != cand) begin
            cand_n  = seg_q;
            cnt_n   = CNT_W'(1);
            state_n = SETTLE;
        end else if (state == SETTLE) begin
            if (cnt < CNT_W'(STABLE_CYCLES - 1)) begin
                cnt_n = cnt + 1'b1;
            end else begin
                // Commit once; STABLE then holds until the pattern moves again.
                cnt_n   = CNT_W'(STABLE_CYCLES);
                state_n = STABLE;
                if (code_legal) begin
                    changed_n = !valid || (code_digit != value);
                    value_n   = code_digit;
                    valid_n   = 1'b1;
                    blank_n   = 1'b0;
                    err_n     = 1'b0;
                end else if (code_blank) begin
                    valid_n = 1'b0;
                    blank_n = 1'b1;
                    err_n   = 1'b0;
                end else begin
                    valid_n = 1'b0;
                    blank_n = 1'b0;
                    err_n   = 1'b1;
                    if (err_count != {ERR_CNT_W{1'b1}})
                        err_count_n = err_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q     <= 7'h7F;
            cand      <= 7'h7F;
            cnt       <= '0;
            state     <= SETTLE;
            value     <= 4'h0;
            valid     <= 1'b0;
            blank     <= 1'b0;
            err       <= 1'b0;
            changed   <= 1'b0;
            err_count <= '0;
        end else begin
            seg_q     <= seg;
            cand      <= cand_n;
            cnt       <= cnt_n;
            state     <= state_n;
            value     <= value_n;
            valid     <= valid_n;
            blank     <= blank_n;
            err       <= err_n;
            changed   <= changed_n;
            err_count <= err_count_n;
        end
    end

endmodule
